// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32 main control FSM.
// Contents: opcode constants, ALU op / mux select encodings, the FSM state enum, the
// registered Moore output bundle and a helper that decodes a state into that bundle.
package riscv_ctrl_pkg;

    // Opcodes (instr[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // alu_op encodings consumed by alu_decoder
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result bus select
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;

    typedef enum logic [3:0] {
        StRstIdle  = 4'd0,
        StFetch    = 4'd1,
        StDecode   = 4'd2,
        StMemAdr   = 4'd3,
        StMemRead  = 4'd4,
        StMemWb    = 4'd5,
        StMemWrite = 4'd6,
        StExecR    = 4'd7,
        StExecI    = 4'd8,
        StAluWb    = 4'd9,
        StBranch   = 4'd10,
        StJal      = 4'd11,
        StIllegal  = 4'd12,
        StBusErr   = 4'd13
    } ctrl_state_e;

    // Outputs that depend on state alone. pc_write here covers only the unconditional JAL
    // case; the FETCH and BRANCH contributions are combined in later.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       pc_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       alu_funct7_en;
        logic [1:0] result_src;
        logic       reg_write;
        logic       illegal_instr;
        logic       bus_error;
    } ctrl_out_t;

    function automatic ctrl_out_t moore_outputs(ctrl_state_e st);
        ctrl_out_t o;
        o = '0;
        case (st)
            StFetch: begin
                o.mem_req    = 1'b1;
                o.alu_src_a  = SRCA_PC;
                o.alu_src_b  = SRCB_FOUR;
                o.alu_op     = ALU_OP_ADD;
                o.result_src = RES_ALURES;
            end
            StDecode: begin
                o.alu_src_a = SRCA_OLDPC;
                o.alu_src_b = SRCB_IMM;
                o.alu_op    = ALU_OP_ADD;
            end
            StMemAdr: begin
                o.alu_src_a = SRCA_RS1;
                o.alu_src_b = SRCB_IMM;
                o.alu_op    = ALU_OP_ADD;
            end
            StMemRead: begin
                o.mem_req = 1'b1;
                o.adr_src = 1'b1;
            end
            StMemWb: begin
                o.result_src = RES_MEMDATA;
                o.reg_write  = 1'b1;
            end
            StMemWrite: begin
                o.mem_req = 1'b1;
                o.mem_we  = 1'b1;
                o.adr_src = 1'b1;
            end
            StExecR: begin
                o.alu_src_a     = SRCA_RS1;
                o.alu_src_b     = SRCB_RS2;
                o.alu_op        = ALU_OP_FUNCT;
                o.alu_funct7_en = 1'b1;
            end
            StExecI: begin
                o.alu_src_a = SRCA_RS1;
                o.alu_src_b = SRCB_IMM;
                o.alu_op    = ALU_OP_FUNCT;
            end
            StAluWb: begin
                o.result_src = RES_ALUOUT;
                o.reg_write  = 1'b1;
            end
            StBranch: begin
                o.alu_src_a  = SRCA_RS1;
                o.alu_src_b  = SRCB_RS2;
                o.alu_op     = ALU_OP_SUB;
                o.result_src = RES_ALUOUT;
            end
            StJal: begin
                o.alu_src_a  = SRCA_OLDPC;
                o.alu_src_b  = SRCB_FOUR;
                o.alu_op     = ALU_OP_ADD;
                o.result_src = RES_ALUOUT;
                o.pc_write   = 1'b1;
            end
            StIllegal: o.illegal_instr = 1'b1;
            StBusErr:  o.bus_error = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/ctrl_mem_timeout.sv
// Memory wait-state watchdog for the main control FSM.
// Ports:
//   clk_i      core clock
//   rst_i      synchronous active-high reset
//   clear_i    zero the counter (not waiting, or the transfer completes this cycle)
//   en_i       FSM is in a memory wait state
//   ready_i    memory completes the request this cycle
//   expired_o  counter already at MEM_TIMEOUT and still no ready: give up this cycle
module ctrl_mem_timeout #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned TMO_W       = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    input  logic ready_i,
    output logic expired_o
);

    localparam logic [TMO_W-1:0] Limit = TMO_W'(MEM_TIMEOUT);

    logic [TMO_W-1:0] count_q, count_d;
    logic             at_limit;

    assign at_limit = (count_q == Limit);

    // Saturates at Limit so a stuck bus can never wrap back into a false "still in time".
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && !ready_i && !at_limit) begin
            count_d = count_q + 1'b1;
        end
    end

    // A ready arriving on the limit cycle is a normal completion, not an error.
    assign expired_o = en_i && !ready_i && at_limit;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle RV32 core.
// Sequences fetch/decode/execute/memory/writeback, drives datapath selects and enables,
// runs the mem_req/mem_ready handshake with a wait timeout, and flags illegal opcodes and
// bus timeouts.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   opcode_i              instr[6:0] from the instruction register
//   zero_i                ALU zero flag (beq decision)
//   mem_ready_i           memory completes the current request
//   mem_req_o, mem_we_o   memory request / write qualifier
//   adr_src_o             0: PC, 1: ALUOut as memory address
//   ir_write_o            load instruction register
//   pc_write_o            load PC from result bus
//   alu_src_a_o/b_o       ALU operand selects
//   alu_op_o              00 ADD, 01 SUB, 10 funct-decoded
//   alu_funct7_en_o       lets funct7[5] through to alu_decoder (R-type only)
//   result_src_o          00 ALUOut, 01 mem data, 10 ALU result
//   reg_write_o           register file write enable
//   illegal_instr_o       illegal opcode seen
//   bus_error_o           memory wait exceeded MEM_TIMEOUT
module multicycle_main_control
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT     = 255,
    parameter int unsigned TMO_W           = 8,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       adr_src_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic       alu_funct7_en_o,
    output logic [1:0] result_src_o,
    output logic       reg_write_o,
    output logic       illegal_instr_o,
    output logic       bus_error_o
);

    ctrl_state_e state_q, state_d;
    ctrl_out_t   out_q;
    logic        in_wait;
    logic        tmo_expired;

    assign in_wait = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);

    ctrl_mem_timeout #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TMO_W       (TMO_W)
    ) u_mem_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (!in_wait || mem_ready_i),
        .en_i      (in_wait),
        .ready_i   (mem_ready_i),
        .expired_o (tmo_expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRstIdle: state_d = StFetch;
            StFetch: begin
                if (mem_ready_i) begin
                    state_d = StDecode;
                end else if (tmo_expired) begin
                    state_d = StBusErr;
                end
            end
            StDecode: begin
                case (opcode_i)
                    OPC_LOAD, OPC_STORE: state_d = StMemAdr;
                    OPC_OP:              state_d = StExecR;
                    OPC_OP_IMM:          state_d = StExecI;
                    OPC_BRANCH:          state_d = StBranch;
                    OPC_JAL:             state_d = StJal;
                    default:             state_d = StIllegal;
                endcase
            end
            StMemAdr: state_d = (opcode_i == OPC_LOAD) ? StMemRead : StMemWrite;
            StMemRead: begin
                if (mem_ready_i) begin
                    state_d = StMemWb;
                end else if (tmo_expired) begin
                    state_d = StBusErr;
                end
            end
            StMemWb: state_d = StFetch;
            StMemWrite: begin
                if (mem_ready_i) begin
                    state_d = StFetch;
                end else if (tmo_expired) begin
                    state_d = StBusErr;
                end
            end
            StExecR, StExecI: state_d = StAluWb;
            StAluWb:          state_d = StFetch;
            StBranch:         state_d = StFetch;
            StJal:            state_d = StAluWb;   // rd <= PC+4 via ALUOut
            StIllegal, StBusErr: state_d = HALT_ON_ILLEGAL ? state_q : StFetch;
            default:          state_d = StRstIdle;
        endcase
    end

    // Moore outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StRstIdle;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= moore_outputs(state_d);
        end
    end

    assign ir_write_o = (state_q == StFetch) && mem_ready_i;
    assign pc_write_o = out_q.pc_write || ir_write_o || ((state_q == StBranch) && zero_i);

    assign mem_req_o       = out_q.mem_req;
    assign mem_we_o        = out_q.mem_we;
    assign adr_src_o       = out_q.adr_src;
    assign alu_src_a_o     = out_q.alu_src_a;
    assign alu_src_b_o     = out_q.alu_src_b;
    assign alu_op_o        = out_q.alu_op;
    assign alu_funct7_en_o = out_q.alu_funct7_en;
    assign result_src_o    = out_q.result_src;
    assign reg_write_o     = out_q.reg_write;
    assign illegal_instr_o = out_q.illegal_instr;
    assign bus_error_o     = out_q.bus_error;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control. Two instances share stimulus: u_halt halts on
// ILLEGAL/BUS_ERR, u_nohalt pulses the flag and refetches. Both use MEM_TIMEOUT=4.
// Each step drives inputs just after a rising edge and compares a packed output vector
// against hand-built expectations a little later in the same cycle.
module tb_multicycle_main_control;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] ADD  = 7'b0110011;
    localparam logic [6:0] ADDI = 7'b0010011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] BAD  = 7'h7F;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       a_req, a_we, a_adr, a_ir, a_pc, a_f7, a_rw, a_ill, a_be;
    logic [1:0] a_sa, a_sb, a_op, a_res;
    logic       b_req, b_we, b_adr, b_ir, b_pc, b_f7, b_rw, b_ill, b_be;
    logic [1:0] b_sa, b_sb, b_op, b_res;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_main_control #(
        .MEM_TIMEOUT     (4),
        .TMO_W           (8),
        .HALT_ON_ILLEGAL (1'b1)
    ) u_halt (
        .clk_i (clk), .rst_i (rst), .opcode_i (opcode), .zero_i (zero),
        .mem_ready_i (mem_ready), .mem_req_o (a_req), .mem_we_o (a_we), .adr_src_o (a_adr),
        .ir_write_o (a_ir), .pc_write_o (a_pc), .alu_src_a_o (a_sa), .alu_src_b_o (a_sb),
        .alu_op_o (a_op), .alu_funct7_en_o (a_f7), .result_src_o (a_res),
        .reg_write_o (a_rw), .illegal_instr_o (a_ill), .bus_error_o (a_be)
    );

    multicycle_main_control #(
        .MEM_TIMEOUT     (4),
        .TMO_W           (8),
        .HALT_ON_ILLEGAL (1'b0)
    ) u_nohalt (
        .clk_i (clk), .rst_i (rst), .opcode_i (opcode), .zero_i (zero),
        .mem_ready_i (mem_ready), .mem_req_o (b_req), .mem_we_o (b_we), .adr_src_o (b_adr),
        .ir_write_o (b_ir), .pc_write_o (b_pc), .alu_src_a_o (b_sa), .alu_src_b_o (b_sb),
        .alu_op_o (b_op), .alu_funct7_en_o (b_f7), .result_src_o (b_res),
        .reg_write_o (b_rw), .illegal_instr_o (b_ill), .bus_error_o (b_be)
    );

    // {req, we, adr, ir, pc, src_a, src_b, alu_op, f7_en, result_src, reg_write, ill, bus_err}
    logic [16:0] obs_a, obs_b;
    assign obs_a = {a_req, a_we, a_adr, a_ir, a_pc, a_sa, a_sb, a_op, a_f7, a_res, a_rw, a_ill, a_be};
    assign obs_b = {b_req, b_we, b_adr, b_ir, b_pc, b_sa, b_sb, b_op, b_f7, b_res, b_rw, b_ill, b_be};

    function automatic logic [16:0] mk(input logic req, input logic we, input logic adr,
                                       input logic ir, input logic pc, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] op,
                                       input logic f7, input logic [1:0] res, input logic rw,
                                       input logic ill, input logic be);
        return {req, we, adr, ir, pc, sa, sb, op, f7, res, rw, ill, be};
    endfunction

    logic [16:0] V_IDLE, V_FW, V_FR, V_DEC, V_MADR, V_MRD, V_MWB, V_MWR, V_EXR, V_EXI;
    logic [16:0] V_AWB, V_BR1, V_BR0, V_JAL, V_ILL, V_BE;

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %05h expected %05h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs after the edge, then compare both instances.
    task automatic step(input logic rdy, input logic z, input logic [6:0] opc, input string tag,
                        input logic [16:0] exp_a, input logic [16:0] exp_b);
        @(posedge clk);
        #1;
        mem_ready = rdy;
        zero      = z;
        opcode    = opc;
        #1;
        check({tag, "_halt"}, obs_a, exp_a);
        check({tag, "_nohalt"}, obs_b, exp_b);
    endtask

    // Assert rst across one edge, check both are idle, release with ready low.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        #1;
        check({tag, "_halt"}, obs_a, V_IDLE);
        check({tag, "_nohalt"}, obs_b, V_IDLE);
        rst = 1'b0;
    endtask

    initial begin
        V_IDLE = '0;
        V_FW   = mk(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b10, 0, 0, 0);
        V_FR   = mk(1, 0, 0, 1, 1, 2'b00, 2'b10, 2'b00, 0, 2'b10, 0, 0, 0);
        V_DEC  = mk(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 0, 2'b00, 0, 0, 0);
        V_MADR = mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 0, 2'b00, 0, 0, 0);
        V_MRD  = mk(1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0);
        V_MWB  = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b01, 1, 0, 0);
        V_MWR  = mk(1, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0);
        V_EXR  = mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 1, 2'b00, 0, 0, 0);
        V_EXI  = mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 0, 2'b00, 0, 0, 0);
        V_AWB  = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 1, 0, 0);
        V_BR1  = mk(0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b01, 0, 2'b00, 0, 0, 0);
        V_BR0  = mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 0, 2'b00, 0, 0, 0);
        V_JAL  = mk(0, 0, 0, 0, 1, 2'b01, 2'b10, 2'b00, 0, 2'b00, 0, 0, 0);
        V_ILL  = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 1, 0);
        V_BE   = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 1);

        rst = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = ADD;
        repeat (2) @(posedge clk);
        #2;
        check("rst_idle_halt", obs_a, V_IDLE);
        check("rst_idle_nohalt", obs_b, V_IDLE);
        rst = 1'b0;

        // add: FETCH (ready immediately) -> DECODE -> EXEC_R -> ALUWB
        step(1, 0, ADD, "add_fetch", V_FR, V_FR);
        step(1, 0, ADD, "add_dec", V_DEC, V_DEC);
        step(1, 0, ADD, "add_exec", V_EXR, V_EXR);
        step(1, 0, ADD, "add_wb", V_AWB, V_AWB);
        // addi: funct7 gate off
        step(1, 0, ADDI, "addi_fetch", V_FR, V_FR);
        step(1, 0, ADDI, "addi_dec", V_DEC, V_DEC);
        step(1, 0, ADDI, "addi_exec", V_EXI, V_EXI);
        step(1, 0, ADDI, "addi_wb", V_AWB, V_AWB);
        // lw: ready ignored in DECODE/MEMADR, then 3 wait cycles in MEMREAD
        step(1, 0, LW, "lw_fetch", V_FR, V_FR);
        step(1, 0, LW, "lw_dec", V_DEC, V_DEC);
        step(1, 0, LW, "lw_madr", V_MADR, V_MADR);
        step(0, 0, LW, "lw_rd_w0", V_MRD, V_MRD);
        step(0, 0, LW, "lw_rd_w1", V_MRD, V_MRD);
        step(0, 0, LW, "lw_rd_w2", V_MRD, V_MRD);
        step(1, 0, LW, "lw_rd_hit", V_MRD, V_MRD);
        step(1, 0, LW, "lw_memwb", V_MWB, V_MWB);
        // sw with one wait cycle
        step(1, 0, SW, "sw_fetch", V_FR, V_FR);
        step(1, 0, SW, "sw_dec", V_DEC, V_DEC);
        step(1, 0, SW, "sw_madr", V_MADR, V_MADR);
        step(0, 0, SW, "sw_wr_w0", V_MWR, V_MWR);
        step(1, 0, SW, "sw_wr_hit", V_MWR, V_MWR);
        // beq taken and not taken
        step(1, 0, BEQ, "beq1_fetch", V_FR, V_FR);
        step(1, 1, BEQ, "beq1_dec", V_DEC, V_DEC);
        step(1, 1, BEQ, "beq1_br", V_BR1, V_BR1);
        step(1, 0, BEQ, "beq0_fetch", V_FR, V_FR);
        step(1, 0, BEQ, "beq0_dec", V_DEC, V_DEC);
        step(1, 0, BEQ, "beq0_br", V_BR0, V_BR0);
        // jal -> ALUWB
        step(1, 0, JAL, "jal_fetch", V_FR, V_FR);
        step(1, 0, JAL, "jal_dec", V_DEC, V_DEC);
        step(1, 0, JAL, "jal_jal", V_JAL, V_JAL);
        step(1, 0, JAL, "jal_wb", V_AWB, V_AWB);
        // illegal opcode: halting instance holds, other pulses then refetches
        step(1, 0, BAD, "ill_fetch", V_FR, V_FR);
        step(1, 0, BAD, "ill_dec", V_DEC, V_DEC);
        step(0, 0, BAD, "ill_flag", V_ILL, V_ILL);
        step(0, 0, BAD, "ill_hold1", V_ILL, V_FW);
        step(0, 0, BAD, "ill_hold2", V_ILL, V_FW);
        // reset while u_nohalt waits in FETCH abandons the request
        do_reset("rst_midwait");
        // ready stuck low: 5 FETCH wait cycles then BUS_ERR
        step(0, 0, ADD, "tmo_w0", V_FW, V_FW);
        step(0, 0, ADD, "tmo_w1", V_FW, V_FW);
        step(0, 0, ADD, "tmo_w2", V_FW, V_FW);
        step(0, 0, ADD, "tmo_w3", V_FW, V_FW);
        step(0, 0, ADD, "tmo_w4", V_FW, V_FW);
        step(0, 0, ADD, "tmo_berr", V_BE, V_BE);
        step(0, 0, ADD, "tmo_hold1", V_BE, V_FW);
        step(0, 0, ADD, "tmo_hold2", V_BE, V_FW);
        do_reset("rst_berr");
        // ready on the 5th (limit) cycle is a normal completion
        step(0, 0, ADD, "lim_w0", V_FW, V_FW);
        step(0, 0, ADD, "lim_w1", V_FW, V_FW);
        step(0, 0, ADD, "lim_w2", V_FW, V_FW);
        step(0, 0, ADD, "lim_w3", V_FW, V_FW);
        step(1, 0, ADD, "lim_hit", V_FR, V_FR);
        step(1, 0, ADD, "lim_dec", V_DEC, V_DEC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
